boreal_vns_scheduler: RTL
=========================

// Module: boreal_vns_scheduler
// PURPOSE
//  Arbitrates and paces VNS stimulation requests ahead of the burst-pulse stimulator
//  (trigger_in / intensity / ad_guard_active / t_wave_inhibit interface).
//  Two requesters share the single stim channel: reward-match events and clinician manual shots.
//  Enforces soft-start intensity ramp, minimum inter-trigger gap, per-window dose cap and inhibit holds.
// PARAMETERS
//  TICK_DIV    100000  clk cycles per scheduler tick (1 ms @ 100 MHz)
//  MIN_GAP_MS  100     min ticks from one trig_out to the next
//  WIN_MS      1000    dose-cap window length in ticks
//  MAX_PER_WIN 16      max grants per window
//  RAMP_STEP   20      intensity increment per grant during soft-start
// PORTS
//  clk               in   1  system clock
//  rst_n             in   1  async active-low reset
//  enable            in   1  scheduler enable; low = clear pending, reset ramp, go IDLE
//  req_reward        in   1  reward-match request, 1-cycle pulse
//  req_manual        in   1  clinician request, 1-cycle pulse, priority over reward
//  target_intensity  in   8  reward-path intensity ceiling (us)
//  manual_intensity  in   8  manual-path intensity (us), no ramp applied
//  ad_guard_active   in   1  fault: flush pending, reset ramp, block
//  t_wave_inhibit    in   1  cardiac blanking: hold pending, no fire
//  stim_busy         in   1  stimulator still delivering a burst
//  trig_out          out  1  1-cycle trigger to stimulator
//  intensity_out     out  8  intensity for the stimulator; valid with trig_out, held after
//  grant_src         out  2  00 none, 01 reward, 10 manual; updated with trig_out, held
//  busy              out  1  high in any state except IDLE
//  cap_hit           out  1  window grant count == MAX_PER_WIN
//  drop_cnt          out  8  saturating count of dropped requests
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, pending flags 0, ramp level 0, tick/window counters 0.
//  Tick: free-running counter 0..TICK_DIV-1; tick strobe 1 cycle at wrap.
//  Pending: per requester, 1-deep flag set on req pulse when enable=1. Request when flag already set,
//   or while cap_hit, or while enable=0 -> dropped, drop_cnt+1 (saturates at 255).
//  Same-cycle req_reward and req_manual: both latched; manual granted first.
//  States: IDLE -> FIRE when any pending && !ad_guard_active && !t_wave_inhibit && !cap_hit && !stim_busy;
//   IDLE -> HOLD when pending && t_wave_inhibit; HOLD -> IDLE when t_wave_inhibit falls (pending kept).
//   FIRE: exactly one cycle; trig_out=1, intensity_out/grant_src loaded, winner flag cleared, window count+1.
//   FIRE -> GAP: gap counter counts ticks; GAP -> IDLE when count>=MIN_GAP_MS && !stim_busy.
//  Latency: req pulse at cycle t (idle, unblocked) -> trig_out at cycle t+2.
//  Ramp (reward only): level = min(level+RAMP_STEP, target_intensity) computed at FIRE, 9-bit add
//   then clamp, never wraps; intensity_out = new level. Manual uses manual_intensity, ramp untouched.
//  Window: counts ticks to WIN_MS then clears grant count and cap_hit on the same tick.
//  ad_guard_active high in any state: pending flushed (not counted as drops), ramp level -> 0,
//   state -> IDLE unless in GAP (GAP completes); trig_out never asserted while high.
//  enable low mid-operation: same as ad_guard flush; gap counter and ramp cleared; window kept.
//  t_wave_inhibit during GAP: no effect on gap counting; only blocks IDLE->FIRE.
//  intensity_out holds last granted value until next FIRE; reset/enable-low do not alter it except reset.
// TESTING  (TICK_DIV=10, MIN_GAP_MS=5, WIN_MS=100, MAX_PER_WIN=3, RAMP_STEP=20)
//  Reset then enable, target=50, req_reward at t -> trig_out at t+2, intensity 20, grant_src 01;
//   next two reward shots after gaps -> 40 then 50 (clamped).
//  req_reward + req_manual same cycle, manual=120 -> manual fires first (120, 10), reward
//   fires >=50 cycles later after gap; drop_cnt stays 0.
//  t_wave_inhibit high, req_reward -> no trig_out, busy=1 (HOLD); inhibit low -> trig_out 2 cycles later.
//  Four reward requests spaced past gap within one window -> 3 grants, cap_hit=1, 4th dropped,
//   drop_cnt=1; after window wrap cap_hit=0 and new request fires.
//  ad_guard_active pulse with reward pending -> no trig_out, pending cleared, next reward
//   grant intensity restarts at 20.
//  Second req_reward while one pending (inhibited) -> drop_cnt+1; async rst_n mid-GAP ->
//   all outputs 0 immediately.

Source files
------------

// File: rtl/boreal_vns_scheduler.sv
// VNS stimulation request scheduler: arbitrates reward/manual requests onto one stim channel,
// applying soft-start ramp, minimum trigger gap, per-window dose cap and inhibit/fault holds.
module boreal_vns_scheduler #(
  parameter int unsigned TICK_DIV    = 100000,
  parameter int unsigned MIN_GAP_MS  = 100,
  parameter int unsigned WIN_MS      = 1000,
  parameter int unsigned MAX_PER_WIN = 16,
  parameter int unsigned RAMP_STEP   = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       req_reward,
  input  logic       req_manual,
  input  logic [7:0] target_intensity,
  input  logic [7:0] manual_intensity,
  input  logic       ad_guard_active,
  input  logic       t_wave_inhibit,
  input  logic       stim_busy,
  output logic       trig_out,
  output logic [7:0] intensity_out,
  output logic [1:0] grant_src,
  output logic       busy,
  output logic       cap_hit,
  output logic [7:0] drop_cnt
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned WW = (WIN_MS > 1) ? $clog2(WIN_MS) : 1;
  localparam int unsigned GW = $clog2(MIN_GAP_MS + 1);
  localparam int unsigned CW = $clog2(MAX_PER_WIN + 1);

  localparam logic [TW-1:0] TickLast = TW'(TICK_DIV - 1);
  localparam logic [WW-1:0] WinLast  = WW'(WIN_MS - 1);
  localparam logic [GW-1:0] GapMin   = GW'(MIN_GAP_MS);
  localparam logic [CW-1:0] CapMax   = CW'(MAX_PER_WIN);
  localparam logic [8:0]    RampInc  = 9'(RAMP_STEP);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StHold = 2'd1;
  localparam logic [1:0] StFire = 2'd2;
  localparam logic [1:0] StGap  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [WW-1:0] win_cnt_q, win_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [CW-1:0] grant_cnt_q, grant_cnt_d;
  logic          pend_rew_q, pend_rew_d;
  logic          pend_man_q, pend_man_d;
  logic [7:0]    ramp_q, ramp_d;
  logic [7:0]    intensity_q, intensity_d;
  logic [1:0]    src_q, src_d;
  logic [7:0]    drop_q, drop_d;

  logic       tick, win_wrap, flush, pend_any, gap_done, grant, grant_rew, grant_man;
  logic       drop_rew, drop_man, set_rew, set_man;
  logic [8:0] ramp_sum, drop_sum;
  logic [7:0] ramp_next;

  assign tick     = (tick_cnt_q == TickLast);
  assign win_wrap = tick && (win_cnt_q == WinLast);
  assign flush    = ad_guard_active || !enable;
  assign pend_any = pend_rew_q || pend_man_q;
  assign gap_done = (gap_cnt_q >= GapMin);
  assign cap_hit  = (grant_cnt_q == CapMax);

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!flush && pend_any) begin
          if (t_wave_inhibit) begin
            state_d = StHold;
          end else if (!cap_hit && !stim_busy) begin
            state_d = StFire;
            grant   = 1'b1;
          end
        end
      end
      StHold:  if (flush || !t_wave_inhibit) state_d = StIdle;
      StFire:  state_d = flush ? StIdle : StGap;
      // A fault lets the gap run out; only disabling the scheduler abandons it.
      StGap:   if (!enable || (gap_done && !stim_busy)) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign grant_man = grant && pend_man_q;
  assign grant_rew = grant && !pend_man_q;

  always_comb begin
    drop_rew   = req_reward && (!enable || (!ad_guard_active && (pend_rew_q || cap_hit)));
    drop_man   = req_manual && (!enable || (!ad_guard_active && (pend_man_q || cap_hit)));
    set_rew    = req_reward && !flush && !pend_rew_q && !cap_hit;
    set_man    = req_manual && !flush && !pend_man_q && !cap_hit;
    pend_rew_d = flush ? 1'b0 : ((pend_rew_q && !grant_rew) || set_rew);
    pend_man_d = flush ? 1'b0 : ((pend_man_q && !grant_man) || set_man);
    drop_sum   = {1'b0, drop_q} + {8'd0, drop_rew} + {8'd0, drop_man};
    drop_d     = drop_sum[8] ? 8'hff : drop_sum[7:0];
  end

  always_comb begin
    ramp_sum    = {1'b0, ramp_q} + RampInc;
    ramp_next   = (ramp_sum > {1'b0, target_intensity}) ? target_intensity : ramp_sum[7:0];
    ramp_d      = ramp_q;
    intensity_d = intensity_q;
    src_d       = src_q;
    if (flush) begin
      ramp_d = 8'd0;
    end else if (grant_rew) begin
      ramp_d      = ramp_next;
      intensity_d = ramp_next;
      src_d       = 2'b01;
    end else if (grant_man) begin
      intensity_d = manual_intensity;
      src_d       = 2'b10;
    end
  end

  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    win_cnt_d  = win_cnt_q;
    if (tick) win_cnt_d = win_wrap ? '0 : win_cnt_q + 1'b1;
    grant_cnt_d = win_wrap ? CW'(grant) : grant_cnt_q + CW'(grant);
    gap_cnt_d   = gap_cnt_q;
    if (!enable || grant) begin
      gap_cnt_d = '0;
    end else if (state_q == StGap && tick && !gap_done) begin
      gap_cnt_d = gap_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      tick_cnt_q  <= '0;
      win_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      grant_cnt_q <= '0;
      pend_rew_q  <= 1'b0;
      pend_man_q  <= 1'b0;
      ramp_q      <= 8'd0;
      intensity_q <= 8'd0;
      src_q       <= 2'b00;
      drop_q      <= 8'd0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      win_cnt_q   <= win_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      grant_cnt_q <= grant_cnt_d;
      pend_rew_q  <= pend_rew_d;
      pend_man_q  <= pend_man_d;
      ramp_q      <= ramp_d;
      intensity_q <= intensity_d;
      src_q       <= src_d;
      drop_q      <= drop_d;
    end
  end

  assign trig_out      = (state_q == StFire) && !ad_guard_active;
  assign intensity_out = intensity_q;
  assign grant_src     = src_q;
  assign busy          = (state_q != StIdle);
  assign drop_cnt      = drop_q;

endmodule
